// File: rtl/rv_byte_packer_if.sv
// rv_byte_packer_if: byte-in / word-out ready-valid bundle for the byte packer
interface rv_byte_packer_if #(
  parameter int BYTES_PER_WORD = 4,
  parameter int COUNT_WIDTH    = $clog2(BYTES_PER_WORD) + 1
);
  logic [7:0]                  input_port_data;
  logic                        input_port_valid;
  logic                        input_port_ready;
  logic [8*BYTES_PER_WORD-1:0] output_port_data;
  logic [COUNT_WIDTH-1:0]      output_port_count;
  logic                        output_port_valid;
  logic                        output_port_ready;
  modport master (
    output input_port_data, input_port_valid, output_port_ready,
    input  input_port_ready, output_port_data, output_port_count, output_port_valid
  );
  modport slave (
    input  input_port_data, input_port_valid, output_port_ready,
    output input_port_ready, output_port_data, output_port_count, output_port_valid
  );
endinterface

// File: rtl/rv_byte_packer.sv
// rv_byte_packer: packs little-endian bytes into words with flush of partial words
module rv_byte_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int COUNT_WIDTH    = $clog2(BYTES_PER_WORD) + 1
) (
  input  logic clock_port,
  input  logic reset_port,
  input  logic flush_port,
  rv_byte_packer_if.slave bus
);
  localparam int W = 8 * BYTES_PER_WORD;
  logic [COUNT_WIDTH-1:0] r_idx, r_count, w_n;
  logic [W-1:0]           r_acc, r_data, w_lane, w_merged;
  logic                   r_valid, r_flush_pending;
  logic                   w_out_free, w_ready, w_accept, w_fl, w_complete, w_load;
  always_comb begin
    w_out_free = ~r_valid | bus.output_port_ready;
    w_ready    = reset_port & ~r_flush_pending &
                 ((r_idx != COUNT_WIDTH'(BYTES_PER_WORD - 1)) | w_out_free);
    w_accept   = bus.input_port_valid & w_ready;
    w_fl       = flush_port | r_flush_pending;
    w_complete = w_accept & (r_idx == COUNT_WIDTH'(BYTES_PER_WORD - 1));
    w_n        = r_idx + COUNT_WIDTH'(w_accept);
    w_lane     = {{(W - 8){1'b0}}, bus.input_port_data} << (8 * r_idx);
    w_merged   = r_acc | (w_accept ? w_lane : '0);
    // a completing byte implies out_free, so w_n == BYTES_PER_WORD covers that case
    w_load     = w_complete | (w_fl & w_out_free & (w_n != '0));
  end
  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      r_idx           <= '0;
      r_acc           <= '0;
      r_data          <= '0;
      r_count         <= '0;
      r_valid         <= 1'b0;
      r_flush_pending <= 1'b0;
    end else begin
      r_idx           <= w_load ? '0 : w_n;
      r_acc           <= w_load ? '0 : w_merged;
      r_data          <= w_load ? w_merged : r_data;
      r_count         <= w_load ? w_n : r_count;
      r_valid         <= w_load | (r_valid & ~bus.output_port_ready);
      r_flush_pending <= w_fl & ~w_out_free;
    end
  end
  assign bus.input_port_ready  = w_ready;
  assign bus.output_port_data  = r_data;
  assign bus.output_port_count = r_count;
  assign bus.output_port_valid = r_valid;
endmodule
